// File: rtl/wdt_rst_req.sv
// Watchdog timer producing a fixed-length, clk-synchronous reset request for the
// core reset controller, configured through a small word-addressed register port.
module wdt_rst_req #(
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned PULSE_LEN = 8,
   parameter logic [31:0] KICK_KEY  = 32'h5A5A_A5A5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic        re_i,
   input  logic [2:0]  addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        irq_o,
   output logic        rst_req_o
);

   localparam int unsigned PW = (PULSE_LEN > 2) ? $clog2(PULSE_LEN) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FIRE} state_t;

   state_t           state;
   logic             en, irq_en, lock;
   logic [CNT_W-1:0] load_q, warn_q, cnt;
   logic             warn_st, cause_st;
   logic [PW-1:0]    pulse_cnt;

   logic wr_cfg, wr_ctrl, wr_load, wr_warn, wr_stat, kick, kick_ok;

   assign wr_cfg  = we_i & ~lock;
   assign wr_ctrl = wr_cfg && (addr_i == 3'd0) && (state != FIRE);
   assign wr_load = wr_cfg && (addr_i == 3'd1);
   assign wr_warn = wr_cfg && (addr_i == 3'd2);
   assign wr_stat = we_i && (addr_i == 3'd5);
   assign kick    = we_i && (addr_i == 3'd3) && (state == RUN);
   assign kick_ok = kick && (wdata_i == KICK_KEY);

   assign irq_o = warn_st & irq_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         en        <= 1'b0;
         irq_en    <= 1'b0;
         lock      <= 1'b0;
         load_q    <= '0;
         warn_q    <= '0;
         cnt       <= '0;
         warn_st   <= 1'b0;
         cause_st  <= 1'b0;
         pulse_cnt <= '0;
         rst_req_o <= 1'b0;
         rdata_o   <= '0;
      end else begin
         if (wr_ctrl) {lock, irq_en, en} <= wdata_i[2:0];
         if (wr_load) load_q <= wdata_i[CNT_W-1:0];
         if (wr_warn) warn_q <= wdata_i[CNT_W-1:0];
         // W1C first so hardware sets later in this block take precedence
         if (wr_stat && wdata_i[0]) warn_st  <= 1'b0;
         if (wr_stat && wdata_i[1]) cause_st <= 1'b0;

         case (state)
            IDLE: begin
               if (wr_ctrl && wdata_i[0]) begin
                  cnt <= load_q;
                  if (load_q == '0) begin
                     state     <= FIRE;
                     rst_req_o <= 1'b1;
                     cause_st  <= 1'b1;
                     pulse_cnt <= PW'(PULSE_LEN - 1);
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if ((cnt == warn_q) && (warn_q != '0)) warn_st <= 1'b1;
               if (wr_ctrl && !wdata_i[0]) begin
                  state <= IDLE;
               end else if ((kick && !kick_ok) || (!kick_ok && cnt == '0)) begin
                  state     <= FIRE;
                  rst_req_o <= 1'b1;
                  cause_st  <= 1'b1;
                  pulse_cnt <= PW'(PULSE_LEN - 1);
               end else if (kick_ok) begin
                  cnt <= load_q;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            FIRE: begin
               if (pulse_cnt == '0) begin
                  state     <= IDLE;
                  rst_req_o <= 1'b0;
                  en        <= 1'b0;
               end else begin
                  pulse_cnt <= pulse_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         if (re_i) begin
            case (addr_i)
               3'd0:    rdata_o <= {29'd0, lock, irq_en, en};
               3'd1:    rdata_o <= 32'(load_q);
               3'd2:    rdata_o <= 32'(warn_q);
               3'd4:    rdata_o <= 32'(cnt);
               3'd5:    rdata_o <= {30'd0, cause_st, warn_st};
               default: rdata_o <= '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wdt_rst_req.sv
// Directed bench for wdt_rst_req: register reads go through an expected-value
// scoreboard, pin behaviour is checked cycle by cycle against hand-derived timing.
module tb_wdt_rst_req;

   localparam logic [31:0] KEY = 32'h5A5A_A5A5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we_i = 1'b0;
   logic        re_i = 1'b0;
   logic [2:0]  addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic [31:0] rdata_o;
   logic        irq_o;
   logic        rst_req_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   wdt_rst_req #(.CNT_W(32), .PULSE_LEN(8), .KICK_KEY(KEY)) dut (
      .clk       (clk),
      .rst       (rst),
      .we_i      (we_i),
      .re_i      (re_i),
      .addr_i    (addr_i),
      .wdata_i   (wdata_i),
      .rdata_o   (rdata_o),
      .irq_o     (irq_o),
      .rst_req_o (rst_req_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // All tasks are entered on a falling edge and return on the next one.
   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      we_i = 1'b1; addr_i = a; wdata_i = d;
      @(negedge clk);
      we_i = 1'b0; wdata_i = '0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] e, input string t);
      re_i = 1'b1; addr_i = a;
      exp_q.push_back(e); tag_q.push_back(t);
      @(negedge clk);
      re_i = 1'b0;
      check(tag_q.pop_front(), rdata_o, exp_q.pop_front());
   endtask

   initial begin
      int m;
      int n;
      bit was_rd;

      // Reset
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_req_after_reset", {31'd0, rst_req_o}, 32'd0);
      check("irq_after_reset", {31'd0, irq_o}, 32'd0);
      rd(3'd4, 32'd0, "count_after_reset");
      rd(3'd5, 32'd0, "status_after_reset");
      wr(3'd6, 32'hFFFF_FFFF);
      rd(3'd6, 32'd0, "addr6_reads_zero");
      rd(3'd3, 32'd0, "kick_reads_zero");

      // Timeout with warning: LOAD=20, WARN=5, CTRL=3
      wr(3'd1, 32'd20);
      wr(3'd2, 32'd5);
      wr(3'd0, 32'd3);
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (i == 15) check("irq_before_warn", {31'd0, irq_o}, 32'd0);
         if (i == 16) check("irq_at_warn", {31'd0, irq_o}, 32'd1);
         check($sformatf("timeout_pulse_c%0d", i), {31'd0, rst_req_o},
               {31'd0, (i >= 21 && i <= 28)});
      end
      rd(3'd5, 32'd3, "status_after_timeout");
      rd(3'd0, 32'd2, "ctrl_en_cleared");
      wr(3'd5, 32'd3);
      rd(3'd5, 32'd0, "status_w1c");
      check("irq_after_w1c", {31'd0, irq_o}, 32'd0);

      // Periodic valid kicks: LOAD=10, CTRL=1
      wr(3'd1, 32'd10);
      wr(3'd0, 32'd1);
      m = 10;
      for (int c = 0; c < 100; c++) begin
         was_rd = (c % 8) != 0;
         if (!was_rd) begin
            we_i = 1'b1; addr_i = 3'd3; wdata_i = KEY;
            m = 10;
         end else begin
            re_i = 1'b1; addr_i = 3'd4;
            exp_q.push_back(32'(m)); tag_q.push_back($sformatf("kick_count_c%0d", c));
            m = m - 1;
         end
         @(negedge clk);
         we_i = 1'b0; re_i = 1'b0; wdata_i = '0;
         if (was_rd) check(tag_q.pop_front(), rdata_o, exp_q.pop_front());
         check($sformatf("kick_no_req_c%0d", c), {31'd0, rst_req_o}, 32'd0);
      end

      // Wrong key fires the next cycle
      wr(3'd3, 32'h0);
      check("badkick_pulse_0", {31'd0, rst_req_o}, 32'd1);
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("badkick_pulse_%0d", i), {31'd0, rst_req_o}, 32'd1);
      end
      @(negedge clk);
      check("badkick_pulse_end", {31'd0, rst_req_o}, 32'd0);
      rd(3'd5, 32'd3, "badkick_status");
      rd(3'd0, 32'd0, "badkick_ctrl");
      wr(3'd5, 32'd3);

      // Lock: later CTRL/LOAD writes ignored, timeout at original LOAD=10
      wr(3'd0, 32'd5);
      wr(3'd0, 32'd0);
      wr(3'd1, 32'd1000);
      rd(3'd0, 32'd5, "locked_ctrl");
      rd(3'd1, 32'd10, "locked_load");
      n = 0;
      while (!rst_req_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("locked_fire_delay", 32'(n), 32'd7);
      repeat (8) @(negedge clk);
      check("locked_pulse_end", {31'd0, rst_req_o}, 32'd0);
      rd(3'd0, 32'd4, "locked_ctrl_after_fire");
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rd(3'd0, 32'd0, "lock_cleared_by_rst");

      // Same-cycle write and read of LOAD returns the old value
      we_i = 1'b1; re_i = 1'b1; addr_i = 3'd1; wdata_i = 32'd4;
      exp_q.push_back(32'd0); tag_q.push_back("wr_rd_same_cycle_old");
      @(negedge clk);
      we_i = 1'b0; re_i = 1'b0; wdata_i = '0;
      check(tag_q.pop_front(), rdata_o, exp_q.pop_front());
      rd(3'd1, 32'd4, "load_written");

      // Valid kick on the cnt==0 cycle wins over expiry
      wr(3'd0, 32'd1);
      repeat (4) @(negedge clk);
      wr(3'd3, KEY);
      check("kick_at_zero_no_req", {31'd0, rst_req_o}, 32'd0);
      rd(3'd4, 32'd4, "count_reloaded");
      rd(3'd4, 32'd3, "count_load_minus_1");
      check("kick_at_zero_still_no_req", {31'd0, rst_req_o}, 32'd0);
      @(negedge clk);
      check("rdata_holds", rdata_o, 32'd3);

      // rst during the third FIRE cycle
      wr(3'd3, 32'h1234_5678);
      check("fire_cycle1", {31'd0, rst_req_o}, 32'd1);
      repeat (2) @(negedge clk);
      check("fire_cycle3", {31'd0, rst_req_o}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_drops_req", {31'd0, rst_req_o}, 32'd0);
      rst = 1'b0;
      rd(3'd5, 32'd0, "cause_cleared_by_rst");
      repeat (10) @(negedge clk);
      check("idle_after_rst_no_req", {31'd0, rst_req_o}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
